// File: rtl/spi_request_arbiter.sv
// rtl/spi_request_arbiter.sv - round-robin arbiter sharing one SPI master between NUM_REQ requesters
// One transaction per grant, CSB-idle gap afterwards, hung-master timeout with sticky error.
module spi_request_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 16,
  parameter int SEL_W       = 3,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] tx_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      busy,
  output logic [SEL_W-1:0]          grant_id,
  output logic                      timeout_err,
  input  logic                      err_clr,
  output logic                      spi_start,
  output logic [DATA_W-1:0]         spi_txdata,
  input  logic                      spi_done,
  input  logic [DATA_W-1:0]         spi_rxdata,
  output logic [SEL_W-1:0]          spi_sel
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC);
  localparam logic [SEL_W-1:0] LAST_ID  = SEL_W'(NUM_REQ - 1);

  logic [2:0]         state;
  logic [SEL_W-1:0]   ptr;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [SEL_W-1:0]   pick;
  logic               pick_vld;
  logic [DATA_W-1:0]  pick_word;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [SEL_W-1:0]   ptr_next;

  // Two passes: requesters below ptr first, then those at/above ptr overwrite,
  // so the lowest set index at or above ptr wins, else the lowest wrapped one.
  always_comb begin
    pick      = '0;
    pick_vld  = 1'b0;
    pick_word = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (SEL_W'(i) < ptr)) begin
        pick      = SEL_W'(i);
        pick_vld  = 1'b1;
        pick_word = tx_data[i*DATA_W +: DATA_W];
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (SEL_W'(i) >= ptr)) begin
        pick      = SEL_W'(i);
        pick_vld  = 1'b1;
        pick_word = tx_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
  assign ptr_next     = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      ack         <= '0;
      rx_data     <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      spi_start   <= 1'b0;
      spi_txdata  <= '0;
      spi_sel     <= '0;
    end else begin
      ack       <= '0;
      spi_start <= 1'b0;
      // A timeout below overrides this clear in the same cycle.
      if (err_clr) timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (enable && pick_vld) begin
            grant_id   <= pick;
            spi_sel    <= pick;
            spi_txdata <= pick_word;
            busy       <= 1'b1;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          spi_start <= 1'b1;
          state     <= S_START;
        end
        S_START: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (spi_done) begin
            rx_data <= spi_rxdata;
            ack     <= grant_onehot;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else if (tmo_cnt == TMO_LAST) begin
            rx_data     <= '0;
            timeout_err <= 1'b1;
            ack         <= grant_onehot;
            gap_cnt     <= '0;
            state       <= S_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_GAP: begin
          // First GAP cycle carries the ack; GAP_CYC idle clocks follow it.
          if (gap_cnt == GAP_LAST) begin
            ptr   <= ptr_next;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_request_arbiter.sv
// tb/tb_spi_request_arbiter.sv - self-checking bench for spi_request_arbiter
// Timestamp-level transaction model compared every cycle, plus directed literal checks.
module tb_spi_request_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int SW  = 3;
  localparam int GAP = 4;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] tx_data = '0;
  logic          err_clr = 1'b0;
  logic          spi_done = 1'b0;
  logic [DW-1:0] spi_rxdata = '0;

  logic [N-1:0]  ack;
  logic [DW-1:0] rx_data;
  logic          busy;
  logic [SW-1:0] grant_id;
  logic          timeout_err;
  logic          spi_start;
  logic [DW-1:0] spi_txdata;
  logic [SW-1:0] spi_sel;

  always #5 clk = ~clk;

  spi_request_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .SEL_W(SW), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .tx_data(tx_data),
    .ack(ack), .rx_data(rx_data), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err), .err_clr(err_clr), .spi_start(spi_start),
    .spi_txdata(spi_txdata), .spi_done(spi_done), .spi_rxdata(spi_rxdata),
    .spi_sel(spi_sel)
  );

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  logic [DW-1:0] txw [N];

  // Model: expected outputs plus transaction timestamps.
  logic [N-1:0]  e_ack = '0;
  logic [DW-1:0] e_rx = '0;
  logic          e_busy = 1'b0;
  logic [SW-1:0] e_gid = '0;
  logic          e_err = 1'b0;
  logic          e_start = 1'b0;
  logic [DW-1:0] e_txd = '0;
  logic [SW-1:0] e_sel = '0;
  bit m_active = 1'b0;
  int m_start = 0;
  int m_free = 0;
  int m_grant = 0;
  int m_ptr = 0;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int j = 0; j < N; j++)
      if (r[(p + j) % N]) return (p + j) % N;
    return -1;
  endfunction

  task automatic model_edge();
    int k;
    bit fin;
    bit tmo;
    int p;
    k = cyc;
    fin = 1'b0;
    tmo = 1'b0;
    e_ack = '0;
    e_start = 1'b0;
    if (rst) begin
      e_rx = '0; e_busy = 1'b0; e_gid = '0; e_err = 1'b0; e_txd = '0; e_sel = '0;
      m_active = 1'b0; m_ptr = 0; m_free = k;
    end else begin
      if (m_active && k == m_start) e_start = 1'b1;
      if (m_active && (k - 1) > m_start) begin
        if (spi_done) begin
          fin = 1'b1;
          e_rx = spi_rxdata;
        end else if ((k - 1) == m_start + TMO - 1) begin
          fin = 1'b1;
          tmo = 1'b1;
          e_rx = '0;
        end
        if (fin) begin
          e_ack[m_grant] = 1'b1;
          m_active = 1'b0;
          m_free = k + GAP + 1;
          m_ptr = (m_grant + 1) % N;
        end
      end
      if (tmo) e_err = 1'b1;
      else if (err_clr) e_err = 1'b0;
      if (!m_active && !fin) begin
        if (k == m_free) begin
          e_busy = 1'b0;
        end else if ((k - 1) >= m_free && enable && req != '0) begin
          p = rr_pick(req, m_ptr);
          m_grant = p;
          m_active = 1'b1;
          m_start = k + 1;
          e_gid = SW'(p);
          e_sel = SW'(p);
          e_txd = tx_data[p*DW +: DW];
          e_busy = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if ({ack, rx_data, busy, grant_id, timeout_err, spi_start, spi_txdata, spi_sel} !==
          {e_ack, e_rx, e_busy, e_gid, e_err, e_start, e_txd, e_sel}) begin
        n_fail++;
        $display("FAIL model cyc=%0d got ack=%b rx=%h busy=%b gid=%0d err=%b start=%b txd=%h sel=%0d want ack=%b rx=%h busy=%b gid=%0d err=%b start=%b txd=%h sel=%0d",
                 cyc, ack, rx_data, busy, grant_id, timeout_err, spi_start, spi_txdata, spi_sel,
                 e_ack, e_rx, e_busy, e_gid, e_err, e_start, e_txd, e_sel);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_tx();
    tx_data = {txw[3], txw[2], txw[1], txw[0]};
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_start(input int max_cyc, output int s);
    int n;
    n = 0;
    s = cyc;
    while (spi_start !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    n_checks++;
    if (spi_start !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_start cyc=%0d got no spi_start want one within %0d cycles", cyc, max_cyc);
    end
    s = cyc;
  endtask

  task automatic run_txn(input int id, input int delay, input logic [DW-1:0] word, output int s);
    wait_start(60, s);
    check("txn grant_id", grant_id, id);
    check("txn spi_sel", spi_sel, id);
    check("txn spi_txdata", spi_txdata, txw[id]);
    repeat (delay) step();
    spi_done = 1'b1;
    spi_rxdata = word;
    step();
    spi_done = 1'b0;
    check("txn ack", ack, 32'(1) << id);
    check("txn rx_data", rx_data, word);
  endtask

  int t0, s, sp, cnt_start, cnt_busy;
  int delays [5] = '{1, 2, 5, 1, 3};
  int ids [5] = '{0, 1, 2, 3, 0};

  initial begin
    txw[0] = 16'h1111; txw[1] = 16'hA5A5; txw[2] = 16'h2222; txw[3] = 16'h3333;
    set_tx();
    step();
    chk_en = 1'b1;
    step();
    check("reset busy", busy, 0);
    check("reset spi_sel", spi_sel, 0);
    check("reset ack", ack, 0);

    // Test 1: single grant, done at c22
    rst = 1'b0;
    req = 4'b0010;
    t0 = cyc;
    step();
    check("t1 spi_sel@c1", spi_sel, 1);
    check("t1 busy@c1", busy, 1);
    step();
    check("t1 spi_start@c2", spi_start, 1);
    check("t1 spi_txdata@c2", spi_txdata, 16'hA5A5);
    wait_until(t0 + 22);
    spi_done = 1'b1;
    spi_rxdata = 16'h1234;
    step();
    spi_done = 1'b0;
    req = '0;
    check("t1 ack@c23", ack, 4'b0010);
    check("t1 rx_data@c23", rx_data, 16'h1234);
    repeat (10) step();

    // Test 3: last grant 2, then 1001 -> 3 then 0
    req = 4'b0100;
    run_txn(2, 2, 16'h0C02, s);
    req = 4'b1001;
    run_txn(3, 1, 16'h0C03, s);
    req = 4'b0001;
    run_txn(0, 4, 16'h0C00, s);
    req = '0;
    repeat (10) step();

    // Test 2: all requesting after reset -> 0,1,2,3,0 with fixed spacing
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    sp = -1;
    for (int i = 0; i < 5; i++) begin
      run_txn(ids[i], delays[i], 16'hB000 + 16'(i), s);
      if (i > 0) check("t2 start spacing", s - sp, delays[i-1] + 8);
      sp = s;
    end
    req = '0;
    repeat (10) step();

    // Test 4: timeout, sticky error, clear, set beats clear
    req = 4'b0001;
    wait_start(60, s);
    wait_until(s + 99);
    check("t4 no ack before timeout", ack, 0);
    step();
    req = '0;
    check("t4 ack@timeout", ack, 4'b0001);
    check("t4 rx_data zero", rx_data, 0);
    check("t4 timeout_err", timeout_err, 1);
    repeat (3) step();
    check("t4 err sticky", timeout_err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t4 err cleared", timeout_err, 0);
    repeat (10) step();
    req = 4'b0001;
    wait_start(60, s);
    wait_until(s + 99);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    req = '0;
    check("t4 set wins over clr", timeout_err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    repeat (10) step();

    // Test 5: reset mid-WAIT, late done ignored
    req = 4'b0010;
    wait_start(60, s);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = '0;
    check("t5 busy after rst", busy, 0);
    check("t5 spi_sel after rst", spi_sel, 0);
    check("t5 spi_txdata after rst", spi_txdata, 0);
    repeat (4) step();
    spi_done = 1'b1;
    spi_rxdata = 16'hBEEF;
    step();
    spi_done = 1'b0;
    check("t5 no ack on late done", ack, 0);
    step();
    check("t5 busy stays 0", busy, 0);
    check("t5 rx_data untouched", rx_data, 0);

    // Test 6: enable gating
    enable = 1'b0;
    req = 4'b0100;
    cnt_start = 0;
    cnt_busy = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (spi_start) cnt_start++;
      if (busy) cnt_busy++;
    end
    check("t6 no start while disabled", cnt_start, 0);
    check("t6 no busy while disabled", cnt_busy, 0);
    enable = 1'b1;
    step();
    check("t6 spi_sel after enable", spi_sel, 2);
    check("t6 busy after enable", busy, 1);
    run_txn(2, 1, 16'h0E02, s);
    req = '0;
    repeat (12) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
